vmmul_seq_engine: RTL

Parametrised, multi-cycle matrix-multiply engine for the vector mmul path. It computes C_out = A*B (+ C_in when accumulating) over DIM x DIM matrices of ELEM_W-bit elements, with OUT_W-bit results. It produces one output element per cycle using DIM parallel multipliers and an adder tree. It generalises the fixed 4x128-bit combinational vector ALU with these additions: configurable dimension and width, signed/unsigned mode, accumulate mode, a start/done handshake and flush.

---
 rtl/vmmul_seq_engine.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vmmul_seq_engine.sv
// Sequential DIM x DIM matrix multiply/accumulate engine: one result element per cycle,
// DIM parallel multipliers feeding an adder tree, result matrix published atomically.
module vmmul_seq_engine #(
    parameter int DIM    = 4,
    parameter int ELEM_W = 8,
    parameter int OUT_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start_i,
    input  logic                        flush_i,
    input  logic                        signed_i,
    input  logic                        accum_i,
    input  logic [DIM*DIM*ELEM_W-1:0]   a_mat_i,
    input  logic [DIM*DIM*ELEM_W-1:0]   b_mat_i,
    input  logic [DIM*DIM*OUT_W-1:0]    c_mat_i,
    output logic                        ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [DIM*DIM*OUT_W-1:0]    c_mat_o
);

    localparam int N     = DIM * DIM;
    localparam int IDX_W = $clog2(DIM * DIM);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [N*ELEM_W-1:0]  a_lat;
    logic [N*ELEM_W-1:0]  b_lat;
    logic [N*OUT_W-1:0]   c_lat;
    logic                 sgn_lat;
    logic                 acc_lat;
    logic [N*OUT_W-1:0]   work;
    logic [N*OUT_W-1:0]   work_next;
    logic [OUT_W-1:0]     elem;
    logic                 accept;
    logic                 last;

    function automatic logic [OUT_W-1:0] extend(input logic [ELEM_W-1:0] v, input logic sgn);
        if (sgn)
            extend = {{(OUT_W-ELEM_W){v[ELEM_W-1]}}, v};
        else
            extend = {{(OUT_W-ELEM_W){1'b0}}, v};
    endfunction

    // flush wins over start; RUN never accepts a new operation
    assign accept  = start_i && !flush_i && (state != RUN);
    assign last    = (idx == IDX_W'(N - 1));
    assign ready_o = (state != RUN);
    assign busy_o  = (state == RUN);
    assign done_o  = (state == DONE);

    always_comb begin
        int row;
        int col;
        elem      = '0;
        work_next = work;
        row       = int'(idx) / DIM;
        col       = int'(idx) % DIM;
        for (int k = 0; k < DIM; k++) begin
            elem = elem + extend(a_lat[(row*DIM + k)*ELEM_W +: ELEM_W], sgn_lat)
                        * extend(b_lat[(k*DIM + col)*ELEM_W +: ELEM_W], sgn_lat);
        end
        if (acc_lat)
            elem = elem + c_lat[int'(idx)*OUT_W +: OUT_W];
        work_next[int'(idx)*OUT_W +: OUT_W] = elem;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = RUN;
            end
            RUN: begin
                if (flush_i)
                    state_next = IDLE;
                else if (last)
                    state_next = DONE;
            end
            DONE: begin
                if (accept)
                    state_next = RUN;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // c_mat_o is only written on the final RUN cycle, so a flushed run never leaks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            c_lat   <= '0;
            sgn_lat <= 1'b0;
            acc_lat <= 1'b0;
            work    <= '0;
            c_mat_o <= '0;
        end else if (accept) begin
            idx     <= '0;
            a_lat   <= a_mat_i;
            b_lat   <= b_mat_i;
            c_lat   <= c_mat_i;
            sgn_lat <= signed_i;
            acc_lat <= accum_i;
        end else if (state == RUN && !flush_i) begin
            work <= work_next;
            if (last)
                c_mat_o <= work_next;
            else
                idx <= idx + 1'b1;
        end
    end

endmodule
